// File: rtl/window_pkg.sv
// ---------------------------------------------------------------------------
// window_pkg: shared width, register map, state encoding and reset defaults
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package window_pkg;

  localparam int W_DEF      = 13;
  localparam int DEF_PERIOD = 4999;
  localparam int DEF_S1     = 3849;
  localparam int DEF_E1     = 4149;
  localparam int DEF_S2     = 3199;
  localparam int DEF_E2     = 3799;

  typedef enum logic [2:0] {
    ADDR_PERIOD = 3'd0,
    ADDR_S1     = 3'd1,
    ADDR_E1     = 3'd2,
    ADDR_S2     = 3'd3,
    ADDR_E2     = 3'd4,
    ADDR_CTRL   = 3'd5,
    ADDR_COMMIT = 3'd6,
    ADDR_NOP    = 3'd7
  } cfg_addr_e;

  typedef enum logic [1:0] {
    ST_STOP     = 2'd0,
    ST_RUN      = 2'd1,
    ST_RUN_PEND = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/window_cmp.sv
// ---------------------------------------------------------------------------
// window_cmp: active-low flag for start <= count < end (empty when start >= end)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module window_cmp
  import window_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] i_count,
  input  logic [W-1:0] i_start,
  input  logic [W-1:0] i_end,
  output logic         o_win_n
);

  assign o_win_n = !((i_count >= i_start) && (i_count < i_end));

endmodule

`default_nettype wire

// File: rtl/window_scheduler.sv
// ---------------------------------------------------------------------------
// window_scheduler: free-running period counter driving two active-low windows,
// with shadow registers committed atomically at a period boundary
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module window_scheduler
  import window_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int P_DEF  = DEF_PERIOD,
  parameter int S1_DEF = DEF_S1,
  parameter int E1_DEF = DEF_E1,
  parameter int S2_DEF = DEF_S2,
  parameter int E2_DEF = DEF_E2
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [2:0]   cfg_addr,
  input  logic [W-1:0] cfg_data,
  output logic         f1,
  output logic         f2,
  output logic [W-1:0] count,
  output logic         wrap
);

  // Register file order: PERIOD, S1, E1, S2, E2
  localparam logic [W-1:0] C_DEF [5] = '{W'(P_DEF), W'(S1_DEF), W'(E1_DEF),
                                         W'(S2_DEF), W'(E2_DEF)};

  state_e       r_state;
  state_e       w_state_nxt;
  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nxt;
  logic [W-1:0] r_sh  [5];
  logic [W-1:0] r_act [5];
  logic         r_f1;
  logic         r_f2;
  cfg_addr_e    w_addr;
  logic         w_wr;
  logic         w_wrap;
  logic         w_commit;
  logic         w_keep_run;
  logic         w_win1_n;
  logic         w_win2_n;

  assign w_addr    = cfg_addr_e'(cfg_addr);
  assign cfg_ready = (r_state != ST_RUN_PEND);
  assign w_wr      = cfg_valid && cfg_ready;
  assign w_wrap    = (r_state != ST_STOP) && (r_count == r_act[0]);

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_commit    = 1'b0;
    case (r_state)
      ST_STOP: begin
        w_count_nxt = '0;
        if (w_wr && (w_addr == ADDR_CTRL) && cfg_data[0]) begin
          w_state_nxt = ST_RUN;
        end
        if (w_wr && (w_addr == ADDR_COMMIT)) begin
          w_commit = 1'b1;
        end
      end
      ST_RUN: begin
        w_count_nxt = w_wrap ? '0 : r_count + W'(1);
        if (w_wr && (w_addr == ADDR_CTRL) && !cfg_data[0]) begin
          w_state_nxt = ST_STOP;
          w_count_nxt = '0;
        end else if (w_wr && (w_addr == ADDR_COMMIT)) begin
          w_state_nxt = ST_RUN_PEND;
        end
      end
      ST_RUN_PEND: begin
        w_count_nxt = w_wrap ? '0 : r_count + W'(1);
        // New set lands together with the count returning to 0
        if (w_wrap) begin
          w_commit    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt = ST_STOP;
        w_count_nxt = '0;
      end
    endcase
  end

  // Windows are forced inactive on the edge that stops the counter
  assign w_keep_run = (r_state != ST_STOP) && (w_state_nxt != ST_STOP);

  window_cmp #(.W(W)) u_cmp_f1 (
    .i_count (r_count),
    .i_start (r_act[1]),
    .i_end   (r_act[2]),
    .o_win_n (w_win1_n)
  );

  window_cmp #(.W(W)) u_cmp_f2 (
    .i_count (r_count),
    .i_start (r_act[3]),
    .i_end   (r_act[4]),
    .o_win_n (w_win2_n)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_RUN;
      r_count <= '0;
      r_sh    <= C_DEF;
      r_act   <= C_DEF;
      r_f1    <= 1'b1;
      r_f2    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_f1    <= w_keep_run ? w_win1_n : 1'b1;
      r_f2    <= w_keep_run ? w_win2_n : 1'b1;
      if (w_wr) begin
        case (w_addr)
          ADDR_PERIOD: r_sh[0] <= cfg_data;
          ADDR_S1:     r_sh[1] <= cfg_data;
          ADDR_E1:     r_sh[2] <= cfg_data;
          ADDR_S2:     r_sh[3] <= cfg_data;
          ADDR_E2:     r_sh[4] <= cfg_data;
          default:     ;
        endcase
      end
      if (w_commit) begin
        r_act <= r_sh;
      end
    end
  end

  assign count = r_count;
  assign f1    = r_f1;
  assign f2    = r_f2;
  assign wrap  = w_wrap;

endmodule

`default_nettype wire
